// File: rtl/bus_dma_master.sv
// Bus initiator for the 65C02 system bus. It halts the CPU through bus_req,
// waits for the grant settle time, then runs one single-byte read or write
// per host command in phi2 timing. It returns one response per command and
// gives the bus back after a number of idle phi2 periods.
module bus_dma_master #(
  parameter int GRANT_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        bus_req,
  output logic        bus_owned,
  output logic [15:0] m_addr,
  output logic        m_rwb,
  output logic [7:0]  m_data_out,
  output logic        m_data_oe,
  input  logic [7:0]  m_data_in
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] OWN  = 3'd2;
  localparam logic [2:0] ARM  = 3'd3;
  localparam logic [2:0] XFER = 3'd4;

  localparam int GW = $clog2(GRANT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [GW-1:0] GRANT_T = GW'(GRANT_CYCLES);
  localparam logic [HW-1:0] HOLD_T  = HW'(HOLD_CYCLES);

  logic [2:0]    state_q, state_d;
  logic          phi2_q;
  logic [GW-1:0] grant_cnt_q, grant_cnt_d, grant_inc;
  logic [HW-1:0] idle_cnt_q, idle_cnt_d, idle_inc;
  logic          bus_req_q, bus_req_d;
  logic          bus_owned_q, bus_owned_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [15:0]   m_addr_q, m_addr_d;
  logic          m_rwb_q, m_rwb_d;
  logic [7:0]    m_data_out_q, m_data_out_d;
  logic          m_data_oe_q, m_data_oe_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          fall, rise;

  // phi2 is only a level sampled on clk; edges become one-clk strobes.
  assign fall = phi2_q & ~phi2;
  assign rise = ~phi2_q & phi2;

  // Counters never pass their target: the state leaves before that can happen.
  assign grant_inc = grant_cnt_q + GW'(1);
  assign idle_inc  = idle_cnt_q + HW'(1);

  assign cmd_ready  = (state_q == OWN);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_owned  = bus_owned_q;
  assign m_addr     = m_addr_q;
  assign m_rwb      = m_rwb_q;
  assign m_data_out = m_data_out_q;
  assign m_data_oe  = m_data_oe_q;

  // Next-state logic for the acquire / transfer / release sequence.
  always_comb begin
    state_d      = state_q;
    grant_cnt_d  = grant_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    bus_req_d    = bus_req_q;
    bus_owned_d  = bus_owned_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    m_addr_d     = m_addr_q;
    m_rwb_d      = m_rwb_q;
    m_data_out_d = m_data_out_q;
    m_data_oe_d  = m_data_oe_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          grant_cnt_d = '0;
        end
      end
      REQ: begin
        // The bus is claimed even if the host withdraws its request here;
        // the hold timer then hands it back.
        if (fall) begin
          grant_cnt_d = grant_inc;
          if (grant_inc == GRANT_T) begin
            state_d     = OWN;
            bus_owned_d = 1'b1;
            idle_cnt_d  = '0;
          end
        end
      end
      OWN: begin
        // An accept wins over a coincident FALL so a waiting command is
        // never lost to the release timer.
        if (cmd_valid) begin
          state_d    = ARM;
          we_d       = cmd_we;
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          idle_cnt_d = '0;
        end else if (fall) begin
          idle_cnt_d = idle_inc;
          if (idle_inc == HOLD_T) begin
            state_d     = IDLE;
            bus_owned_d = 1'b0;
            bus_req_d   = 1'b0;
          end
        end
      end
      ARM: begin
        if (fall) begin
          state_d  = XFER;
          m_addr_d = addr_q;
          m_rwb_d  = ~we_q;
        end
      end
      XFER: begin
        if (fall) begin
          state_d     = OWN;
          rsp_rdata_d = we_q ? 8'h00 : m_data_in;
          rsp_valid_d = 1'b1;
          m_rwb_d     = 1'b1;
          m_data_oe_d = 1'b0;
          idle_cnt_d  = '0;
        end else if (rise && we_q) begin
          m_data_out_d = wdata_q;
          m_data_oe_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset drops any in-flight command and releases the bus at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      phi2_q       <= 1'b0;
      grant_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      bus_req_q    <= 1'b0;
      bus_owned_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      m_addr_q     <= 16'h0000;
      m_rwb_q      <= 1'b1;
      m_data_out_q <= 8'h00;
      m_data_oe_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      phi2_q       <= phi2;
      grant_cnt_q  <= grant_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_owned_q  <= bus_owned_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      m_addr_q     <= m_addr_d;
      m_rwb_q      <= m_rwb_d;
      m_data_out_q <= m_data_out_d;
      m_data_oe_q  <= m_data_oe_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Testbench for bus_dma_master. A stimulus process issues commands, and a
// flat-memory reference model predicts each response into a queue. A
// monitor pops the queue and compares whenever rsp_valid appears. A bus-side
// RAM model answers the DUT's cycles and records its writes.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        phi2 = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        bus_req;
  logic        bus_owned;
  logic [15:0] m_addr;
  logic        m_rwb;
  logic [7:0]  m_data_out;
  logic        m_data_oe;
  logic [7:0]  m_data_in;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] wr_addrs[$];
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int   compared = 0;
  int   mismatched = 0;
  int   accepts = 0;
  int   rsps = 0;
  int   owned_drops = 0;
  logic saw_oe = 1'b0;
  logic prev_owned = 1'b0;

  bus_dma_master #(.GRANT_CYCLES(2), .HOLD_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .phi2       (phi2),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .bus_req    (bus_req),
    .bus_owned  (bus_owned),
    .m_addr     (m_addr),
    .m_rwb      (m_rwb),
    .m_data_out (m_data_out),
    .m_data_oe  (m_data_oe),
    .m_data_in  (m_data_in)
  );

  assign m_data_in = mem[m_addr];

  always #5 clk = ~clk;

  // phi2: 10 clk period, changing just after a rising clk edge.
  initial begin
    forever begin
      repeat (5) @(posedge clk);
      #1 phi2 = ~phi2;
    end
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h8000) return 8'hA9;
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus-side RAM/ROM: latches write data on the falling phi2 edge.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    forever begin
      @(negedge phi2);
      if (rst && bus_owned && m_data_oe) begin
        check("oe_while_read", {31'd0, m_rwb}, 32'd0);
        mem[m_addr] = m_data_out;
      end
    end
  end

  // Response monitor and protocol watch.
  always @(negedge clk) begin
    if (!rst) begin
      saw_oe     = 1'b0;
      prev_owned = 1'b0;
    end else begin
      if (m_data_oe) saw_oe = 1'b1;
      if (cmd_valid && cmd_ready) accepts++;
      if (cmd_ready) check("ready_without_owned", {31'd0, bus_owned}, 32'd1);
      if (prev_owned && !bus_owned) owned_drops++;
      prev_owned = bus_owned;
      if (rsp_valid) begin
        rsps++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rsp: got rdata 0x%0h, expected no response", rsp_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_e.rdata});
          check("rsp_addr", {16'd0, m_addr}, {16'd0, mon_e.addr});
          check("rsp_write_oe", {31'd0, saw_oe}, {31'd0, mon_e.we});
        end
        saw_oe = 1'b0;
      end
    end
  end

  // Offer a command and hold it until accepted; optionally record its prediction.
  task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d, input bit track);
    bit ok = 1'b0;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got cmd_ready 0 for 400 clks, expected 1");
      cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      if (we) begin
        ref_mem[a] = d;
        wr_addrs.push_back(a);
        exp_q.push_back('{we: 1'b1, addr: a, rdata: 8'h00});
      end else begin
        exp_q.push_back('{we: 1'b0, addr: a, rdata: ref_mem[a]});
      end
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL rsp_timeout: got %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int          falls;
    logic        prev;
    int          a0, r0, d0;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        rw;
    bit          seen;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));

    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_ctl", {26'd0, bus_req, bus_owned, cmd_ready, rsp_valid, m_rwb, m_data_oe},
          32'b000010);
    check("reset_data", {rsp_rdata, m_addr, m_data_out}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Read of ROM 0x8000 from IDLE, with cmd_valid held throughout.
    a0 = accepts;
    r0 = rsps;
    prev = phi2;
    falls = 0;
    cmd_we = 1'b0;
    cmd_addr = 16'h8000;
    cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("req_next_clk", {31'd0, bus_req}, 32'd1);
    check("ready_in_req", {31'd0, cmd_ready}, 32'd0);
    if (prev && !phi2) falls++;
    prev = phi2;
    for (int k = 0; k < 100 && !bus_owned; k++) begin
      @(negedge clk);
      if (prev && !phi2) falls++;
      prev = phi2;
    end
    check("grant_falls", falls, 32'd2);
    check("owned_after_grant", {31'd0, bus_owned}, 32'd1);
    issue(1'b0, 16'h8000, 8'h00, 1'b1);
    wait_rsp();
    repeat (3) @(negedge clk);
    check("one_accept", accepts - a0, 32'd1);
    check("one_rsp", rsps - r0, 32'd1);

    // Write 0x1234 <= 0x5A.
    issue(1'b1, 16'h1234, 8'h5A, 1'b1);
    wait_rsp();
    check("mem_1234", {24'd0, mem[16'h1234]}, 32'h5A);

    // Write then read 0x7FFF back to back: the bus must stay owned.
    d0 = owned_drops;
    issue(1'b1, 16'h7FFF, 8'hC3, 1'b1);
    wait_rsp();
    issue(1'b0, 16'h7FFF, 8'h00, 1'b1);
    wait_rsp();
    check("owned_held", owned_drops - d0, 32'd0);

    // Release with no further command: first FALL after the response.
    prev = phi2;
    falls = 0;
    for (int k = 0; k < 100 && bus_owned; k++) begin
      @(negedge clk);
      if (prev && !phi2) falls++;
      prev = phi2;
    end
    check("release_falls", falls, 32'd1);
    check("release_req", {30'd0, bus_req, bus_owned}, 32'd0);

    // Randomized traffic, including boundary addresses and re-acquisition gaps.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) repeat (30) @(negedge clk);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       ra = 16'h0000;
        1:       ra = 16'hFFFF;
        2:       ra = 16'h8000;
        default: ra = 16'h0100 + 16'($urandom_range(0, 15));
      endcase
      rd = 8'($urandom);
      issue(rw, ra, rd, 1'b1);
      wait_rsp();
    end
    foreach (wr_addrs[i]) check("mem_after_write", {24'd0, mem[wr_addrs[i]]}, {24'd0, ref_mem[wr_addrs[i]]});

    // Reset in the middle of a write's data phase.
    repeat (20) @(negedge clk);
    issue(1'b1, 16'hFFF0, ~ref_mem[16'hFFF0], 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_data_oe) begin
        seen = 1'b1;
        break;
      end
    end
    check("oe_reached", {31'd0, seen}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_ctl", {27'd0, m_data_oe, m_rwb, bus_req, bus_owned, rsp_valid}, 32'b01000);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_mem", {24'd0, mem[16'hFFF0]}, {24'd0, ref_mem[16'hFFF0]});
    issue(1'b0, 16'h0000, 8'h00, 1'b1);
    wait_rsp();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
